mmio_interconnect: RTL and testbench
====================================

Name: mmio_interconnect

Overview:
Parametrised single-master to N-slave memory-mapped interconnect. It replaces the hand-written address decode and ready/rdata mux in the SoC top. It sits between the picorv32 native memory port and N slaves (ROM, FRAM, RAM, peripherals) and adds registered response, per-access timeout, unmapped-address error response and sticky error logging.

Parameters:
N_SLAVES, 4, number of slave ports (1..16)
SLV_BASE, {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, packed N_SLAVES*32 base addresses; slave 0 in bits [31:0]
SLV_MASK, {32'hFFFF_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000}, packed N_SLAVES*32 compare masks; hit i = ((mem_addr & MASK_i) == BASE_i)
TIMEOUT, 256, WAIT cycles before timeout error; 0 disables timeout
ERR_RDATA, 32'hDEAD_BEEF, read data returned on error responses

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
mem_valid  in  1  master request
mem_addr  in  32  master address
mem_wdata  in  32  master write data
mem_wstrb  in  4  master byte strobes (0 = read)
mem_ready  out  1  one-cycle response strobe, registered
mem_rdata  out  32  response data, registered, valid while mem_ready=1
s_valid  out  N_SLAVES  one-hot slave request
s_addr  out  32  mem_addr passed through
s_wdata  out  32  mem_wdata passed through
s_wstrb  out  4  mem_wstrb passed through
s_ready  in  N_SLAVES  per-slave ready
s_rdata  in  N_SLAVES*32  per-slave read data, slave 0 in [31:0]
err_clear  in  1  clears error log
err_flag  out  1  sticky: at least one error since clear
err_cause  out  2  cause of first logged error: 01 unmapped, 10 timeout
err_addr  out  32  address of first logged error
err_count  out  8  saturating error count since clear

Behaviour:
- Reset (async, active-high): state IDLE; mem_ready=0, mem_rdata=0, s_valid=0, err_flag=0, err_cause=0, err_addr=0, err_count=0, timeout counter=0. Reset asserted mid-transaction drops s_valid immediately; the transaction is lost.
- Decode: combinational in IDLE. Lowest index wins on overlapping regions. The selected index is latched on leaving IDLE and held until IDLE.
- FSM states: IDLE, WAIT, DONE.
- IDLE with mem_valid=1 and a hit: latch sel and go to WAIT; clear the counter.
- IDLE with mem_valid=1 and no hit: go to DONE with rdata=ERR_RDATA and log cause 01.
- WAIT: s_valid[sel]=1, all other bits 0. s_valid is decoded from state and sel, so it has no combinational path from mem_addr.
- WAIT with s_ready[sel]=1: capture s_rdata[sel] and go to DONE. s_ready of non-selected slaves is ignored.
- WAIT with no ready: counter increments. At counter==TIMEOUT-1 (TIMEOUT>0), go to DONE with ERR_RDATA and log cause 10. If ready and timeout occur in the same cycle, ready wins.
- WAIT with mem_valid=0 (aborted master): return to IDLE, no response, no error.
- DONE: mem_ready=1 for exactly one cycle with the captured mem_rdata; then IDLE. mem_rdata holds its last value otherwise.
- Writes follow the same path; mem_rdata content is don't-care for writes except on error (ERR_RDATA).
- Latency from mem_valid rising:
  - mapped access with a slave ready in its first s_valid cycle: mem_ready 2 cycles later;
  - each extra slave wait cycle adds 1;
  - unmapped access: mem_ready 1 cycle later.
- Back-to-back: a new request is accepted in the IDLE cycle following DONE.
- Error log:
  - On an error with err_flag=0: set err_flag and load err_cause and err_addr.
  - On an error with err_flag=1: err_cause and err_addr are unchanged.
  - err_count increments on every error and saturates at 255.
  - err_clear zeroes flag, cause, addr and count. If err_clear and an error occur in the same cycle, the error is logged as first error and count=1.
- s_addr, s_wdata and s_wstrb are direct combinational passthroughs of the master signals.

Test Plan:
- Read 0x2000_0010 (wstrb=0), slave 2 raises s_ready 3 cycles after s_valid with s_rdata=0x1234_5678 -> s_valid=4'b0100 for 4 cycles; mem_ready pulses 1 cycle after s_ready; mem_rdata=0x1234_5678; no error.
- Unmapped read 0x3000_0000 -> s_valid stays 0; mem_ready the cycle after request; mem_rdata=0xDEAD_BEEF; err_flag=1, err_cause=01, err_addr=0x3000_0000, err_count=1.
- TIMEOUT=8, write 0x4000_1000 to slave 3, which never becomes ready -> s_valid[3] high exactly 8 cycles; then mem_ready with 0xDEAD_BEEF; cause 01 retained from the previous error; err_count=2.
- err_clear asserted in the same cycle as an unmapped error at 0x5000_0000 -> err_flag=1, err_cause=01, err_addr=0x5000_0000, err_count=1. A further err_clear alone -> all error outputs 0.
- Overlap: SLV_BASE0=SLV_BASE1=0x0, masks 0xFF00_0000, read 0x0000_0004 -> only s_valid[0] asserted.
- reset raised in the second WAIT cycle -> s_valid=0 and mem_ready=0 in the same cycle, before the next clk edge. After release, a new mapped request completes normally.

Source files
------------

// File: rtl/mmio_interconnect.sv
// Single-master to N-slave MMIO interconnect: address decode, registered response, per-access timeout, unmapped-address error and sticky error log.
// Latency: mapped 2 cycles + slave wait cycles, unmapped 1 cycle; master is held via mem_ready until the slave answers or the timeout fires.
module mmio_interconnect #(
  parameter int                     N_SLAVES  = 4,
  parameter logic [N_SLAVES*32-1:0] SLV_BASE  = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0] SLV_MASK  = {32'hFFFF_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000},
  parameter int                     TIMEOUT   = 256,
  parameter logic [31:0]            ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [N_SLAVES-1:0]      s_valid,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_wstrb,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic [N_SLAVES*32-1:0]   s_rdata,
  input  logic                     err_clear,
  output logic                     err_flag,
  output logic [1:0]               err_cause,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);

  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state_q;
  logic [SW-1:0] sel_q;
  logic [CW-1:0] cnt_q;
  logic          mem_ready_q;
  logic [31:0]   mem_rdata_q;
  logic          err_flag_q;
  logic [1:0]    err_cause_q;
  logic [31:0]   err_addr_q;
  logic [7:0]    err_count_q;

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          sel_ready;
  logic [31:0]   sel_rdata;
  logic          tmo;
  logic          err_evt;
  logic [1:0]    err_cause_d;

  assign s_addr    = mem_addr;
  assign s_wdata   = mem_wdata;
  assign s_wstrb   = mem_wstrb;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign err_flag  = err_flag_q;
  assign err_cause = err_cause_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((mem_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  always_comb begin
    s_valid = '0;
    if (state_q == S_WAIT) s_valid[sel_q] = 1'b1;
  end

  assign sel_ready   = s_ready[sel_q];
  assign sel_rdata   = s_rdata[32*int'(sel_q) +: 32];
  assign tmo         = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign err_evt     = ((state_q == S_IDLE) && mem_valid && !hit) ||
                       ((state_q == S_WAIT) && mem_valid && !sel_ready && tmo);
  assign err_cause_d = (state_q == S_IDLE) ? 2'b01 : 2'b10;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      mem_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_valid) begin
            if (hit) begin
              sel_q   <= hit_idx;
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end else begin
              mem_rdata_q <= ERR_RDATA;
              mem_ready_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (!mem_valid) begin
            state_q <= S_IDLE;
          end else if (sel_ready) begin
            mem_rdata_q <= sel_rdata;
            mem_ready_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (tmo) begin
            mem_rdata_q <= ERR_RDATA;
            mem_ready_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A clear coinciding with an error restarts the log with that error as the first one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag_q  <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else if (err_clear) begin
      err_flag_q  <= err_evt;
      err_cause_q <= err_evt ? err_cause_d : 2'b00;
      err_addr_q  <= err_evt ? mem_addr : 32'h0;
      err_count_q <= err_evt ? 8'd1 : 8'd0;
    end else if (err_evt) begin
      if (!err_flag_q) begin
        err_flag_q  <= 1'b1;
        err_cause_q <= err_cause_d;
        err_addr_q  <= mem_addr;
      end
      if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Bench for mmio_interconnect: directed scenarios plus randomized accesses checked against a decode/latency/error-log reference model.
module tb_mmio_interconnect;

  localparam logic [31:0] ERR_RD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_valid;
  logic [31:0]  mem_addr, mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         err_clear;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic [3:0]   s_valid;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic         err_flag;
  logic [1:0]   err_cause;
  logic [31:0]  err_addr;
  logic [7:0]   err_count;

  logic         mem_ready_ov;
  logic [31:0]  mem_rdata_ov;
  logic [1:0]   s_valid_ov;
  logic [31:0]  s_addr_ov, s_wdata_ov;
  logic [3:0]   s_wstrb_ov;
  logic [1:0]   s_ready_ov = 2'b00;
  logic [63:0]  s_rdata_ov = 64'h0;
  logic         err_flag_ov;
  logic [1:0]   err_cause_ov;
  logic [31:0]  err_addr_ov;
  logic [7:0]   err_count_ov;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_base[4];
  logic [31:0] m_mask[4];
  logic        m_flag;
  logic [1:0]  m_cause;
  logic [31:0] m_addr;
  int          m_count;

  always #5 clk = ~clk;

  mmio_interconnect #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .err_clear(err_clear),
    .err_flag(err_flag), .err_cause(err_cause), .err_addr(err_addr), .err_count(err_count)
  );

  mmio_interconnect #(
    .N_SLAVES(2),
    .SLV_BASE({32'h0000_0000, 32'h0000_0000}),
    .SLV_MASK({32'hFF00_0000, 32'hFF00_0000}),
    .TIMEOUT(0)
  ) dut_ov (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready_ov),
    .mem_rdata(mem_rdata_ov), .s_valid(s_valid_ov), .s_addr(s_addr_ov), .s_wdata(s_wdata_ov),
    .s_wstrb(s_wstrb_ov), .s_ready(s_ready_ov), .s_rdata(s_rdata_ov), .err_clear(err_clear),
    .err_flag(err_flag_ov), .err_cause(err_cause_ov), .err_addr(err_addr_ov), .err_count(err_count_ov)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_flag = 1'b0; m_cause = 2'b00; m_addr = 32'h0; m_count = 0;
  endtask

  task automatic model_err(input logic [1:0] c, input logic [31:0] a);
    if (!m_flag) begin
      m_flag = 1'b1; m_cause = c; m_addr = a;
    end
    if (m_count < 255) m_count++;
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_err_flag"},  err_flag,  m_flag);
    chk({tag, "_err_cause"}, err_cause, m_cause);
    chk({tag, "_err_addr"},  err_addr,  m_addr);
    chk({tag, "_err_count"}, err_count, m_count);
  endtask

  // delay: slave wait cycles before ready; negative or >= TIMEOUT means the slave never answers.
  task automatic do_access(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rd, input bit clr);
    int idx, lat, sv, exp_lat, exp_sv;
    logic [3:0]  exp_oh;
    logic [31:0] exp_rd;
    bit is_err, done;
    idx = decode(addr);
    lat = 0; sv = 0; done = 0; is_err = 0;
    exp_oh = (idx >= 0) ? (4'b0001 << idx) : 4'b0000;
    if (clr) model_clear();
    if (idx < 0) begin
      exp_lat = 1; exp_sv = 0; exp_rd = ERR_RD; is_err = 1; model_err(2'b01, addr);
    end else if (delay >= 0 && delay <= 7) begin
      exp_lat = delay + 2; exp_sv = delay + 1; exp_rd = rd;
    end else begin
      exp_lat = 9; exp_sv = 8; exp_rd = ERR_RD; is_err = 1; model_err(2'b10, addr);
    end
    mem_addr = addr; mem_wstrb = wstrb; mem_wdata = wdata; mem_valid = 1'b1; err_clear = clr;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      err_clear = 1'b0;
      if (mem_ready) begin
        done = 1;
      end else begin
        if (s_valid != 4'b0000) begin
          sv++;
          chk("s_valid_onehot", s_valid, exp_oh);
        end
        s_ready = 4'($urandom_range(0, 15)) & ~exp_oh;
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (s_valid != 4'b0000 && sv - 1 == delay && idx >= 0) begin
          s_ready = s_ready | exp_oh;
          s_rdata[32*idx +: 32] = rd;
        end
      end
    end
    chk("response_seen", done, 1'b1);
    chk("latency", lat, exp_lat);
    chk("s_valid_cycles", sv, exp_sv);
    chk("s_valid_in_done", s_valid, 4'b0000);
    if (wstrb == 4'b0000 || is_err) chk("mem_rdata", mem_rdata, exp_rd);
    chk_log("resp");
    mem_valid = 1'b0; s_ready = 4'b0000;
    @(posedge clk); #1;
    chk("ready_one_cycle", mem_ready, 1'b0);
  endtask

  initial begin
    logic [7:0]  tops[7];
    logic [31:0] a;
    logic [3:0]  ws;
    logic [7:0]  cnt_before;
    m_base = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000};
    m_mask = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_0000};
    tops   = '{8'h00, 8'h10, 8'h20, 8'h40, 8'h40, 8'h30, 8'h77};
    model_clear();
    reset = 1'b1; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    err_clear = 1'b0; s_ready = 4'h0; s_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_ready", mem_ready, 1'b0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_s_valid", s_valid, 4'h0);
    chk_log("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Slave 2 answers after three wait cycles.
    do_access(32'h2000_0010, 4'h0, 32'h0, 3, 32'h1234_5678, 1'b0);
    chk("passthru_addr", s_addr, 32'h2000_0010);
    do_access(32'h3000_0000, 4'h0, 32'h0, 0, 32'h0, 1'b0);
    do_access(32'h4000_1000, 4'hF, 32'hCAFE_F00D, -1, 32'h0, 1'b0);
    chk("timeout_count", err_count, 8'd2);
    do_access(32'h5000_0000, 4'h0, 32'h0, 0, 32'h0, 1'b1);
    chk("clr_same_cycle_count", err_count, 8'd1);

    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    model_clear();
    chk_log("clear_alone");

    // Slave ready in the very cycle the timeout would fire.
    do_access(32'h0000_0100, 4'h0, 32'h0, 7, 32'hA5A5_0007, 1'b0);

    // Overlapping regions, then an aborted access on both instances.
    cnt_before = err_count;
    mem_addr = 32'h0000_0004; mem_wstrb = 4'h0; mem_valid = 1'b1;
    @(posedge clk); #1;
    chk("overlap_s_valid", s_valid_ov, 2'b01);
    chk("overlap_main_s_valid", s_valid, 4'b0001);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_s_valid", s_valid, 4'h0);
    chk("abort_ov_s_valid", s_valid_ov, 2'b00);
    chk("abort_mem_ready", mem_ready, 1'b0);
    @(posedge clk); #1;
    chk("abort_no_response", mem_ready, 1'b0);
    chk("abort_no_error", err_count, cnt_before);

    // Reset during the second WAIT cycle.
    mem_addr = 32'h1000_0020; mem_wstrb = 4'h0; mem_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_s_valid", s_valid, 4'b0010);
    #1 reset = 1'b1;
    #1;
    chk("midrst_s_valid", s_valid, 4'h0);
    chk("midrst_mem_ready", mem_ready, 1'b0);
    model_clear();
    chk_log("midrst");
    mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_access(32'h1000_0020, 4'h0, 32'h0, 1, 32'h0BAD_F00D, 1'b0);

    for (int n = 0; n < 40; n++) begin
      a = {tops[$urandom_range(0, 6)], 24'($urandom)};
      if (a[31:24] == 8'h40 && $urandom_range(0, 1) == 1) a[23:16] = 8'h00;
      ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      do_access(a, ws, $urandom, $urandom_range(0, 9), $urandom, 1'b0);
    end

    for (int n = 0; n < 258; n++)
      do_access(32'h3000_0000 + 32'(n), 4'h0, 32'h0, 0, 32'h0, 1'b0);
    chk("count_saturated", err_count, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
